// File: rtl/pri_sel_param_if.sv
// Handshake bundle for pri_sel_param: priority word set in, resolved winner out.
// Both sides are valid/ready; the slave modport is the selector's view.
interface pri_sel_param_if #(
  parameter int N = 16,
  parameter int P = 16,
  parameter int C = (P > 1) ? $clog2(P) : 1
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [C-1:0]  in_pri [0:N-1];
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  win_mask;
  logic [C-1:0]  max_pri;
  logic          any_req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_pri, in_valid, out_ready,
    output in_ready, win_mask, max_pri, any_req, grant, grant_idx, out_valid
  );

  modport master (
    output in_pri, in_valid, out_ready,
    input  in_ready, win_mask, max_pri, any_req, grant, grant_idx, out_valid
  );
endinterface

// File: rtl/pri_sel_param.sv
// Bit-serial (BPC bits/cycle, MSB first) maximum-priority selector with one-hot grant.
// Define PRI_SEL_RR_TIEBREAK_EN for round-robin tie-break; default is lowest-index wins.
module pri_sel_param #(
  parameter int N   = 16,
  parameter int P   = 16,
  parameter int C   = (P > 1) ? $clog2(P) : 1,
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           reset,
  pri_sel_param_if.slave bus
);
  localparam int L  = (C + BPC - 1) / BPC;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int CB = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [C-1:0]  data_q [0:N-1];
  logic [C-1:0]  data_d [0:N-1];
  logic [N-1:0]  mask_q, mask_d;
  logic [C-1:0]  max_q, max_d;
  logic          armed_q;
  logic [N-1:0]  cand;
  logic [CB-1:0] bi;
  int            b;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel_idx;
  logic          done;
  logic          any_q;

  // First set bit of m at or after ptr, searching upward modulo N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] m, input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic [IW-1:0] jj;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      jj = IW'((int'(ptr) + k) % N);
      if (!found && m[jj]) begin
        idx   = jj;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      max_q   <= '0;
      armed_q <= 1'b0;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      max_q   <= max_d;
      armed_q <= 1'b1;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;
    max_d   = max_q;
    cand    = '0;
    bi      = '0;
    b       = 0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && armed_q) begin
          data_d = bus.in_pri;
          for (int i = 0; i < N; i++) mask_d[i] = |bus.in_pri[i];
          max_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Narrow the candidate set one bit at a time; a bit below 0 in the last group is skipped.
        for (int j = 0; j < BPC; j++) begin
          b = C - 1 - int'(cnt_q) * BPC - j;
          if (b >= 0) begin
            bi = CB'(b);
            for (int i = 0; i < N; i++) cand[i] = mask_d[i] & data_q[i][bi];
            if (cand != '0) begin
              mask_d    = cand;
              max_d[bi] = 1'b1;
            end else begin
              max_d[bi] = 1'b0;
            end
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(L - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done    = (state_q == DONE);
  assign any_q   = |mask_q;
  assign sel_idx = pick(mask_q, rr_ptr);

`ifdef PRI_SEL_RR_TIEBREAK_EN
  logic [IW-1:0] rr_q, rr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  // Pointer moves just past the winner, only when someone actually won.
  always_comb begin
    rr_d = rr_q;
    if (done && bus.out_ready && any_q)
      rr_d = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = '0;
`endif

  assign bus.in_ready  = (state_q == IDLE) && armed_q;
  assign bus.out_valid = done;
  assign bus.win_mask  = done ? mask_q : '0;
  assign bus.max_pri   = done ? max_q : '0;
  assign bus.any_req   = done && any_q;
  assign bus.grant_idx = (done && any_q) ? sel_idx : '0;
  assign bus.grant     = (done && any_q) ? (N'(1) << sel_idx) : '0;
endmodule

// File: tb/tb_pri_sel_param.sv
// Bench for pri_sel_param: three instances (BPC=1,2,4) fed identical stimulus,
// each with its own expected-result queue.
module tb_pri_sel_param;
  localparam int N = 4;
  localparam int P = 16;
  localparam int C = 4;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [C-1:0] maxp;
    logic         any;
    logic [N-1:0] gnt;
    logic [1:0]   idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic out_ready;
  logic [C-1:0] pri [0:N-1];

  always #5 clk = ~clk;

  pri_sel_param_if #(.N(N), .P(P), .C(C)) bus0 ();
  pri_sel_param_if #(.N(N), .P(P), .C(C)) bus1 ();
  pri_sel_param_if #(.N(N), .P(P), .C(C)) bus2 ();

  assign bus0.in_pri = pri;  assign bus0.in_valid = in_valid;  assign bus0.out_ready = out_ready;
  assign bus1.in_pri = pri;  assign bus1.in_valid = in_valid;  assign bus1.out_ready = out_ready;
  assign bus2.in_pri = pri;  assign bus2.in_valid = in_valid;  assign bus2.out_ready = out_ready;

  pri_sel_param #(.N(N), .P(P), .C(C), .BPC(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  pri_sel_param #(.N(N), .P(P), .C(C), .BPC(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  pri_sel_param #(.N(N), .P(P), .C(C), .BPC(4)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sbq0 [$];
  exp_t sbq1 [$];
  exp_t sbq2 [$];
  exp_t last_e;
  int   acc_cyc [3];
  int   lat_obs [3];
  bit   prev_ov [3];
  int   lat_exp [3] = '{4, 2, 1};
`ifdef PRI_SEL_RR_TIEBREAK_EN
  logic [1:0] rr_m = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon(input int g, input logic ov, input logic ordy, input logic iv, input logic ir,
                     input logic [N-1:0] m, input logic [C-1:0] mx, input logic any,
                     input logic [N-1:0] gnt, input logic [1:0] idx);
    exp_t e;
    int   qs;
    e = '0;
    if (iv && ir) acc_cyc[g] = cyc + 1;
    if (ov && !prev_ov[g]) lat_obs[g] = cyc - acc_cyc[g];
    prev_ov[g] = ov;
    if (ov && ordy) begin
      case (g)
        0: qs = sbq0.size();
        1: qs = sbq1.size();
        default: qs = sbq2.size();
      endcase
      check($sformatf("d%0d_pending", g), 32'(qs != 0), 1);
      if (qs != 0) begin
        case (g)
          0: e = sbq0.pop_front();
          1: e = sbq1.pop_front();
          default: e = sbq2.pop_front();
        endcase
        check($sformatf("d%0d_win_mask", g), 32'(m), 32'(e.mask));
        check($sformatf("d%0d_max_pri", g), 32'(mx), 32'(e.maxp));
        check($sformatf("d%0d_any_req", g), 32'(any), 32'(e.any));
        check($sformatf("d%0d_grant", g), 32'(gnt), 32'(e.gnt));
        check($sformatf("d%0d_grant_idx", g), 32'(idx), 32'(e.idx));
        check($sformatf("d%0d_latency", g), 32'(lat_obs[g]), 32'(lat_exp[g]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, bus0.out_valid, bus0.out_ready, bus0.in_valid, bus0.in_ready, bus0.win_mask,
          bus0.max_pri, bus0.any_req, bus0.grant, bus0.grant_idx);
      mon(1, bus1.out_valid, bus1.out_ready, bus1.in_valid, bus1.in_ready, bus1.win_mask,
          bus1.max_pri, bus1.any_req, bus1.grant, bus1.grant_idx);
      mon(2, bus2.out_valid, bus2.out_ready, bus2.in_valid, bus2.in_ready, bus2.win_mask,
          bus2.max_pri, bus2.any_req, bus2.grant, bus2.grant_idx);
    end
  end

  function automatic logic all_ready();
    return bus0.in_ready && bus1.in_ready && bus2.in_ready;
  endfunction

  // Build the expected result, queue it for every instance, then present one word set.
  task automatic send(input logic [C-1:0] a, input logic [C-1:0] b, input logic [C-1:0] c,
                      input logic [C-1:0] d);
    exp_t       e;
    logic [C-1:0] mx;
    logic [1:0] jj;
    logic       found;
    for (int t = 0; t < 50 && !all_ready(); t++) begin
      @(posedge clk); #1;
    end
    check("ready_wait", 32'(all_ready()), 1);
    pri[0] = a; pri[1] = b; pri[2] = c; pri[3] = d;
    mx = '0;
    for (int i = 0; i < N; i++) if (pri[i] > mx) mx = pri[i];
    e = '0;
    e.maxp = mx;
    e.any  = (mx != 0);
    for (int i = 0; i < N; i++) e.mask[i] = e.any && (pri[i] == mx);
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
`ifdef PRI_SEL_RR_TIEBREAK_EN
      jj = 2'(int'(rr_m) + k);
`else
      jj = 2'(k);
`endif
      if (!found && e.mask[jj]) begin
        e.idx = jj;
        found = 1'b1;
      end
    end
    e.gnt = e.any ? (N'(1) << e.idx) : '0;
`ifdef PRI_SEL_RR_TIEBREAK_EN
    if (e.any) rr_m = e.idx + 2'd1;
`endif
    sbq0.push_back(e);
    sbq1.push_back(e);
    sbq2.push_back(e);
    last_e = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && !(sbq0.size() == 0 && sbq1.size() == 0 && sbq2.size() == 0 && all_ready()); t++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) pri[i] = '0;
    prev_ov = '{0, 0, 0};
    acc_cyc = '{0, 0, 0};
    lat_obs = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus0.in_ready), 0);
    check("rst_out_valid", 32'(bus0.out_valid), 0);
    check("rst_grant", 32'(bus0.grant), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus0.in_ready), 1);

    // Basic ties and tie-break progression on a repeated word set
    send(4'd3, 4'd9, 4'd9, 4'd0);  drain();
    send(4'd3, 4'd9, 4'd9, 4'd0);  drain();
    send(4'd3, 4'd9, 4'd9, 4'd0);  drain();
    send(4'd5, 4'd7, 4'd7, 4'd6);  drain();
    send(4'd0, 4'd0, 4'd0, 4'd0);  drain();
    send(4'd15, 4'd1, 4'd15, 4'd15); drain();
    send(4'd0, 4'd0, 4'd4, 4'd0);  drain();
    for (int r = 0; r < 6; r++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drain();
    end

    // Back-pressure: result held, busy input ignored
    out_ready = 1'b0;
    send(4'd2, 4'd8, 4'd1, 4'd8);
    for (int t = 0; t < 20 && !bus0.out_valid; t++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        for (int i = 0; i < N; i++) pri[i] = 4'd5;
        in_valid = 1'b1;
      end
      if (c == 3) in_valid = 1'b0;
      check("hold_out_valid", 32'(bus0.out_valid), 1);
      check("hold_in_ready", 32'(bus0.in_ready), 0);
      check("hold_win_mask", 32'(bus0.win_mask), 32'(last_e.mask));
      check("hold_max_pri", 32'(bus0.max_pri), 32'(last_e.maxp));
      check("hold_grant_idx", 32'(bus0.grant_idx), 32'(last_e.idx));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(bus0.in_ready), 1);
    check("release_out_valid", 32'(bus0.out_valid), 0);
    drain();

    // Asynchronous reset in the second scan cycle
    send(4'd6, 4'd2, 4'd6, 4'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus0.out_valid), 0);
    check("abort_win_mask", 32'(bus0.win_mask), 0);
    check("abort_max_pri", 32'(bus0.max_pri), 0);
    check("abort_any_req", 32'(bus0.any_req), 0);
    check("abort_grant", 32'(bus0.grant), 0);
    check("abort_in_ready", 32'(bus0.in_ready), 0);
    check("abort_d2_out_valid", 32'(bus2.out_valid), 0);
    sbq0.delete();
    sbq1.delete();
    sbq2.delete();
    prev_ov = '{0, 0, 0};
`ifdef PRI_SEL_RR_TIEBREAK_EN
    rr_m = '0;
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_rel_in_ready", 32'(bus0.in_ready), 1);
    send(4'd1, 4'd0, 4'd0, 4'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
